// File: rtl/dmem_dump_unit_pkg.sv
// rtl/dmem_dump_unit_pkg.sv - shared state type and defaults for the data-memory dump unit
package mips_dbg_pkg;

  // Dump sequencer states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } dump_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Word counter width and the largest dump it can index
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CNT_MAX = 65535;

  // Defaults shared by the core top and the bench
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0030;
  localparam logic [31:0] DEF_END_PC    = 32'h0000_0030;
  localparam int unsigned DEF_COUNT     = 96;
  localparam int unsigned DEF_ROW_LEN   = 16;

endpackage

// File: rtl/dmem_dump_unit_if.sv
// rtl/dmem_dump_unit_if.sv - memory read port and output stream bundle of the dump unit
interface dmem_dump_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);

  // Data-memory read port
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  // Output word stream
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [15:0]       out_index;
  logic              out_row_end;
  logic              out_last;

  // Dump unit side
  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_rdata,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_index,
    output out_row_end,
    output out_last
  );

  // Memory and consumer side
  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_rdata,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_index,
    input  out_row_end,
    input  out_last
  );

endinterface

// File: rtl/dmem_dump_unit.sv
// rtl/dmem_dump_unit.sv - reads a block of data memory when the PC hits END_PC and streams it out
module dmem_dump_unit
  import mips_dbg_pkg::*;
#(
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter int unsigned        COUNT     = DEF_COUNT,
  parameter int unsigned        ROW_LEN   = DEF_ROW_LEN,
  parameter logic [ADDR_W-1:0]  END_PC    = ADDR_W'(DEF_END_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              rearm,
  dmem_dump_unit_if.master  bus,
  output logic              busy,
  output logic              done
);

  // Reject parameter sets the 16-bit counter or row logic cannot represent
  generate
    if (COUNT > CNT_MAX) begin : g_bad_count
      $error("dmem_dump_unit: COUNT must fit the 16-bit word counter");
    end
    if (ROW_LEN < 1) begin : g_bad_row_len
      $error("dmem_dump_unit: ROW_LEN must be at least 1");
    end
  endgenerate

  dump_state_t       r_state;
  dump_state_t       w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_out_index;
  logic              r_row_end;
  logic              r_last;

  logic              w_trigger;
  logic              w_xfer;
  logic              w_row_end;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr_nxt;

  // pc only matters while idle, so a held trigger PC cannot restart a finished dump
  assign w_trigger = (r_state == IDLE) && (pc == END_PC);
  assign w_xfer    = (r_state == SEND) && bus.out_ready;

  // Markers for the word currently addressed by the counter
  assign w_row_end = ((32'(r_cnt) + 32'd1) % ROW_LEN) == 32'd0;
  assign w_last    = (32'(r_cnt) + 32'd1) == COUNT;

  // Address wraps modulo 2^ADDR_W by construction of the adder width
  assign w_addr_nxt = BASE_ADDR + (ADDR_W'(w_cnt_nxt) * ADDR_W'(BYTES_PER_WORD));

  // Next-state, counter and state-decoded outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    bus.mem_rd    = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trigger) begin
          if (COUNT == 0) begin
            w_state_nxt = DONE;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = READ;
          end
        end
      end
      READ: begin
        bus.mem_rd  = 1'b1;
        busy        = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        busy        = 1'b1;
        w_state_nxt = SEND;
      end
      SEND: begin
        bus.out_valid = 1'b1;
        busy          = 1'b1;
        if (w_xfer) begin
          if (r_last) begin
            w_state_nxt = DONE;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_state_nxt = READ;
          end
        end
      end
      DONE: begin
        done = 1'b1;
        // rearm wins over a coincident trigger PC; the trigger is seen next cycle in IDLE
        if (rearm) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and word counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Read address is loaded on entry to READ and held otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_addr <= '0;
    end else if (w_state_nxt == READ) begin
      r_mem_addr <= w_addr_nxt;
    end
  end

  // Capture the returned word and its markers in WAIT; they stay frozen through SEND
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_data  <= '0;
      r_out_index <= '0;
      r_row_end   <= 1'b0;
      r_last      <= 1'b0;
    end else if (r_state == WAIT) begin
      r_out_data  <= bus.mem_rdata;
      r_out_index <= r_cnt;
      r_row_end   <= w_row_end;
      r_last      <= w_last;
    end
  end

  assign bus.mem_addr    = r_mem_addr;
  assign bus.out_data    = r_out_data;
  assign bus.out_index   = r_out_index;
  assign bus.out_row_end = r_row_end;
  assign bus.out_last    = r_last;

endmodule

// File: tb/tb_dmem_dump_unit.sv
// tb/tb_dmem_dump_unit.sv - scoreboard bench for dmem_dump_unit
module tb_dmem_dump_unit;
  import mips_dbg_pkg::*;

  localparam int unsigned N    = DEF_COUNT;
  localparam int unsigned RL   = DEF_ROW_LEN;
  localparam logic [31:0] BASE = DEF_BASE_ADDR;
  localparam logic [31:0] TRIG = DEF_END_PC;

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] index;
    logic        row_end;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, pc0;
  logic        rearm, rearm0;
  logic        busy, done, busy0, done0;

  int          checks = 0;
  int          errors = 0;
  int          ready_mode;
  logic        seen0;
  logic        prev_stall;
  beat_t       exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  dmem_dump_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  dmem_dump_unit_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();

  dmem_dump_unit #(
    .DATA_W(32), .ADDR_W(32), .BASE_ADDR(BASE), .COUNT(N), .ROW_LEN(RL), .END_PC(TRIG)
  ) u_dut (
    .clk(clk), .reset(reset), .pc(pc), .rearm(rearm), .bus(bus.master), .busy(busy), .done(done)
  );

  dmem_dump_unit #(
    .DATA_W(32), .ADDR_W(32), .BASE_ADDR(BASE), .COUNT(0), .ROW_LEN(RL), .END_PC(TRIG)
  ) u_dut0 (
    .clk(clk), .reset(reset), .pc(pc0), .rearm(rearm0), .bus(bus0.master), .busy(busy0), .done(done0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: word i of the dump is memory word BASE/4+i, with markers from the row/count rules
  task automatic push_dump();
    beat_t b;
    for (int i = 0; i < int'(N); i++) begin
      b.data    = 32'hA000_0000 + BASE / 4 + 32'(i);
      b.index   = 16'(i);
      b.row_end = ((i + 1) % RL) == 0;
      b.last    = (i == int'(N) - 1);
      exp_q.push_back(b);
      addr_q.push_back(BASE + 32'(4 * i));
    end
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("done_reached", done, 1);
  endtask

  // Synchronous read memory: data appears the cycle after the strobe
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    bus.mem_rdata  = '0;
    bus0.mem_rdata = '0;
    bus0.out_ready = 1'b1;
  end

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
  end

  // Consumer ready: always high or ~30% random duty
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
    end
  end

  // Monitor: compares reads and presented beats against the scoreboard queues
  initial begin : monitor
    beat_t e;
    prev_stall = 1'b0;
    seen0      = 1'b0;
    forever begin
      @(negedge clk);
      if (bus0.mem_rd || bus0.out_valid) seen0 = 1'b1;
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        if (bus.mem_rd) begin
          if (addr_q.size() == 0) check("unexpected_read", 1, 0);
          else check("mem_addr", bus.mem_addr, addr_q.pop_front());
        end
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            e = exp_q[0];
            check("out_data", bus.out_data, e.data);
            check("out_index", bus.out_index, e.index);
            check("out_row_end", bus.out_row_end, e.row_end);
            check("out_last", bus.out_last, e.last);
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end else if (prev_stall) begin
          check("valid_dropped_in_stall", 0, 1);
        end
        prev_stall = bus.out_valid && !bus.out_ready;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int cyc;
    int k;
    ready_mode = 0;
    reset  = 1'b0;
    pc     = '0;
    pc0    = '0;
    rearm  = 1'b0;
    rearm0 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_index", bus.out_index, 0);
    check("rst_row_end", bus.out_row_end, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;

    // No trigger: unit stays idle
    repeat (50) begin
      @(negedge clk);
      check("idle_mem_rd", bus.mem_rd, 0);
      check("idle_valid", bus.out_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
    end
    check("idle_done0", done0, 0);

    // Full dump with ready tied high, including latency and throughput
    push_dump();
    pc = TRIG;
    @(negedge clk);
    check("lat_mem_rd", bus.mem_rd, 1);
    check("first_addr", bus.mem_addr, BASE);
    @(negedge clk);
    check("lat_wait_valid", bus.out_valid, 0);
    @(negedge clk);
    check("lat_out_valid", bus.out_valid, 1);
    wait_done(2000, cyc);
    check("cycles_to_done", 3 + cyc, 3 * N + 1);
    check("beats_left", exp_q.size(), 0);
    check("reads_left", addr_q.size(), 0);

    // Trigger PC held in DONE: no new reads
    repeat (20) begin
      @(negedge clk);
      check("done_hold_rd", bus.mem_rd, 0);
      check("done_hold_done", done, 1);
    end

    // Rearm with PC still at trigger: IDLE first, then a repeat dump under random ready
    ready_mode = 1;
    push_dump();
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    check("rearm_idle_done", done, 0);
    check("rearm_idle_rd", bus.mem_rd, 0);
    wait_done(20000, cyc);
    check("rand_beats_left", exp_q.size(), 0);

    // Reset during beat 40, then retrigger from scratch
    push_dump();
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    k = 0;
    while (!(bus.out_valid && bus.out_index == 16'd40) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("reached_index40", bus.out_index, 40);
    #1;
    reset = 1'b0;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    check("abort_valid", bus.out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_index", bus.out_index, 0);
    check("abort_mem_addr", bus.mem_addr, 0);
    pc = '0;
    ready_mode = 0;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("post_abort_idle", busy, 0);
    push_dump();
    pc = TRIG;
    @(negedge clk);
    check("restart_rd", bus.mem_rd, 1);
    check("restart_addr", bus.mem_addr, BASE);
    wait_done(2000, cyc);
    check("restart_beats_left", exp_q.size(), 0);

    // COUNT=0 instance: straight to DONE, never reads or emits
    pc0 = TRIG;
    @(negedge clk);
    check("count0_done", done0, 1);
    check("count0_busy", busy0, 0);
    repeat (10) @(negedge clk);
    check("count0_no_activity", seen0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_dump_unit.md
Name: dmem_dump_unit

Overview:
- Read-side companion to the pipelined MIPS core's data memory.
- Watches the core's PC. When the PC reaches a configured end address, it reads a block of data-memory words through a synchronous read port.
- Streams the words out over a valid/ready interface, with index and row markers, to a bench printer or a debug UART.
- Replaces ad-hoc hierarchical memory dumps with a synthesizable, checkable reader.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, byte-address width of the memory port and PC.
- BASE_ADDR, 32'h30, byte address of the first word dumped (word index 12).
- COUNT, 96, number of words dumped; legal range 0..65535.
- ROW_LEN, 16, words per output row; must be at least 1.
- END_PC, 32'h30, PC value that triggers the dump.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- pc  in  ADDR_W  current PC of the core.
- rearm  in  1  one-cycle pulse; returns the unit from DONE to IDLE.
- mem_rd  out  1  read strobe to the data-memory read port.
- mem_addr  out  ADDR_W  byte address for the read.
- mem_rdata  in  DATA_W  read data, valid exactly one cycle after mem_rd.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  dumped word.
- out_index  out  16  word index within the dump, 0..COUNT-1.
- out_row_end  out  1  high with word i when (i+1) mod ROW_LEN == 0.
- out_last  out  1  high with word COUNT-1.
- busy  out  1  high in READ, WAIT and SEND.
- done  out  1  high while in DONE.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, word counter=0.
  - All outputs are 0: mem_rd, mem_addr, out_valid, out_data, out_index, out_row_end, out_last, busy, done.
  - Reset mid-dump aborts without completing a handshake. After release the unit waits for a fresh trigger.
- Trigger:
  - Condition is pc==END_PC, sampled only in IDLE.
  - Level-sensitive, but taken once: the unit leaves IDLE and ignores pc until it is back in IDLE.
- State machine:
  - IDLE: on trigger, if COUNT==0 go to DONE; else counter=0 and go to READ.
  - READ: mem_rd=1, mem_addr=BASE_ADDR+4*counter. Go to WAIT.
  - WAIT: mem_rd=0. Register mem_rdata into out_data, counter into out_index, and compute out_row_end and out_last. Go to SEND.
  - SEND: out_valid=1.
    - Word is transferred on a cycle with out_valid&&out_ready.
    - On transfer: if out_last go to DONE, else counter+=1 and go to READ.
    - Without transfer: hold in SEND.
  - DONE: done=1. If rearm, go to IDLE. pc is ignored.
- Latency:
  - Trigger sampled at edge T gives mem_rd high in cycle T+1.
  - out_valid rises in cycle T+3.
  - With out_ready tied high, one word is emitted every 3 cycles.
- Handshake rules:
  - While out_valid is high and out_ready is low, out_data, out_index, out_row_end and out_last stay stable.
  - out_valid never drops without a transfer, except on reset.
  - out_ready high before valid has no effect.
- Width rules:
  - mem_addr is computed modulo 2^ADDR_W; wrap past the top of the address space is permitted, not flagged.
  - Counter is 16 bits; COUNT>65535 is illegal and checked by an elaboration assertion.
- Simultaneous events:
  - rearm outside DONE is ignored.
  - rearm and pc==END_PC in the same DONE cycle go to IDLE only; the trigger is evaluated on the next cycle.
- mem_addr holds its last driven value when mem_rd is low; the memory must qualify reads on mem_rd.

Decomposition:
- Shared package mips_dbg_pkg holds:
  - the state enum (IDLE, READ, WAIT, SEND, DONE);
  - the byte-per-word constant 4;
  - default BASE_ADDR, END_PC and COUNT, for reuse by bench and core top.
- No sub-module: the FSM, counter and output register fit in one module of about 150 lines.

Test Plan:
- Reset release, pc held at 0 for 50 cycles -> mem_rd and out_valid stay 0, busy=0, done=0.
- Memory preloaded with word i = 32'hA000_0000+i. pc=32'h30, out_ready=1 ->
  - 96 beats with out_data = A000_000C..A000_006B;
  - out_index 0..95;
  - out_row_end on indices 15, 31, …, 95;
  - out_last only on index 95;
  - first mem_addr=32'h30, last 32'h1AC;
  - done=1 afterwards.
- Same run with out_ready random ~30% duty -> identical beat sequence; fields stable during every stall.
- Drive reset low during the beat with out_index=40, then release and retrigger -> dump restarts at index 0, mem_addr=32'h30.
- After done, pc stays 32'h30 -> no new reads. Pulse rearm -> IDLE, then the dump repeats.
- COUNT=0, trigger -> done=1 next cycle, no mem_rd and no out_valid ever.
